// File: rtl/ascon_pack.sv
// Shared types, constants and helpers for the ASCON permutation.
// Build option: PERM_UNROLL2_EN (two rounds per cycle), used in ascon_permutation.
package ascon_pack;

  typedef logic [0:4][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } perm_state_e;

  localparam int unsigned NUM_COLS = 64;
  localparam int unsigned LAST_RND = 11;

  localparam int unsigned ROT_X0_A = 19;
  localparam int unsigned ROT_X0_B = 28;
  localparam int unsigned ROT_X1_A = 61;
  localparam int unsigned ROT_X1_B = 39;
  localparam int unsigned ROT_X2_A = 1;
  localparam int unsigned ROT_X2_B = 6;
  localparam int unsigned ROT_X3_A = 10;
  localparam int unsigned ROT_X3_B = 17;
  localparam int unsigned ROT_X4_A = 7;
  localparam int unsigned ROT_X4_B = 41;

  // 0xf0 at r=0 down to 0x4b at r=11.
  function automatic logic [7:0] round_const(
    input logic [3:0] r
  );
    return {~r, r};
  endfunction

  function automatic logic [63:0] ror64(
    input logic [63:0] x,
    input int unsigned k
  );
    return (x >> k) | (x << (64 - k));
  endfunction

endpackage

// File: rtl/ascon_permutation_diffusion_layer.sv
// ASCON linear diffusion layer pL, purely combinational.
module diffusion_layer
  import ascon_pack::*;
(
  input  type_state s_i,
  output type_state s_o
);

  assign s_o[0] = s_i[0]
                ^ ror64(s_i[0], ROT_X0_A)
                ^ ror64(s_i[0], ROT_X0_B);
  assign s_o[1] = s_i[1]
                ^ ror64(s_i[1], ROT_X1_A)
                ^ ror64(s_i[1], ROT_X1_B);
  assign s_o[2] = s_i[2]
                ^ ror64(s_i[2], ROT_X2_A)
                ^ ror64(s_i[2], ROT_X2_B);
  assign s_o[3] = s_i[3]
                ^ ror64(s_i[3], ROT_X3_A)
                ^ ror64(s_i[3], ROT_X3_B);
  assign s_o[4] = s_i[4]
                ^ ror64(s_i[4], ROT_X4_A)
                ^ ror64(s_i[4], ROT_X4_B);

endmodule

// File: rtl/ascon_sbox.sv
// ASCON 5-bit substitution box, one bit column.
// Input/output bit 4 is x0, bit 0 is x4.
module ascon_sbox (
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);

  always_comb begin
    y_o = 5'h00;
    unique case (x_i)
      5'h00: y_o = 5'h04;
      5'h01: y_o = 5'h0b;
      5'h02: y_o = 5'h1f;
      5'h03: y_o = 5'h14;
      5'h04: y_o = 5'h1a;
      5'h05: y_o = 5'h15;
      5'h06: y_o = 5'h09;
      5'h07: y_o = 5'h02;
      5'h08: y_o = 5'h1b;
      5'h09: y_o = 5'h05;
      5'h0a: y_o = 5'h08;
      5'h0b: y_o = 5'h12;
      5'h0c: y_o = 5'h1d;
      5'h0d: y_o = 5'h03;
      5'h0e: y_o = 5'h06;
      5'h0f: y_o = 5'h1c;
      5'h10: y_o = 5'h1e;
      5'h11: y_o = 5'h13;
      5'h12: y_o = 5'h07;
      5'h13: y_o = 5'h0e;
      5'h14: y_o = 5'h00;
      5'h15: y_o = 5'h0d;
      5'h16: y_o = 5'h11;
      5'h17: y_o = 5'h18;
      5'h18: y_o = 5'h10;
      5'h19: y_o = 5'h0c;
      5'h1a: y_o = 5'h01;
      5'h1b: y_o = 5'h19;
      5'h1c: y_o = 5'h16;
      5'h1d: y_o = 5'h0a;
      5'h1e: y_o = 5'h0f;
      5'h1f: y_o = 5'h17;
      default: y_o = 5'h00;
    endcase
  end

endmodule

// File: rtl/ascon_permutation.sv
// Iterative ASCON permutation, 1..12 rounds on the 320-bit state.
// Define PERM_UNROLL2_EN to chain two rounds per clock.
module ascon_permutation
  import ascon_pack::*;
#(
  parameter int MAX_ROUNDS = 12
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] nrounds_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o
);

`ifdef PERM_UNROLL2_EN
  localparam int UNR = 2;
`else
  localparam int UNR = 1;
`endif

  localparam logic [3:0] MAX_N = 4'(MAX_ROUNDS);
  localparam logic [3:0] STEP  = 4'(UNR);

  perm_state_e st_q, st_d;
  logic [3:0]  rnd_q, rnd_d;
  type_state   work_q, work_d;
  type_state   out_q, out_d;

  logic [3:0]  n_eff;
  logic        last;
  type_state   nxt;
  type_state   chain [UNR+1];

  always_comb begin
    if (nrounds_i == 4'd0) begin
      n_eff = 4'd1;
    end else if (nrounds_i > MAX_N) begin
      n_eff = MAX_N;
    end else begin
      n_eff = nrounds_i;
    end
  end

  assign chain[0] = work_q;

  for (genvar g = 0; g < UNR; g++) begin : g_rnd
    logic [3:0] rc_idx;
    type_state  pc;
    type_state  sb;
    logic [4:0] col [NUM_COLS];

    assign rc_idx = rnd_q + 4'(g);

    always_comb begin
      pc = chain[g];
      pc[2][7:0] = chain[g][2][7:0] ^ round_const(rc_idx);
    end

    for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
      ascon_sbox u_sbox (
        .x_i ({pc[0][j], pc[1][j], pc[2][j],
               pc[3][j], pc[4][j]}),
        .y_o (col[j])
      );
    end

    always_comb begin
      sb = '0;
      for (int j = 0; j < NUM_COLS; j++) begin
        sb[0][j] = col[j][4];
        sb[1][j] = col[j][3];
        sb[2][j] = col[j][2];
        sb[3][j] = col[j][1];
        sb[4][j] = col[j][0];
      end
    end

    diffusion_layer u_pl (
      .s_i (sb),
      .s_o (chain[g+1])
    );
  end

`ifdef PERM_UNROLL2_EN
  // Odd counts end on r=11 with a single round.
  assign last = (rnd_q >= 4'(LAST_RND - 1));
  assign nxt  = (rnd_q == 4'(LAST_RND)) ? chain[1]
                                        : chain[2];
`else
  assign last = (rnd_q == 4'(LAST_RND));
  assign nxt  = chain[1];
`endif

  always_comb begin
    st_d   = st_q;
    rnd_d  = rnd_q;
    work_d = work_q;
    out_d  = out_q;
    unique case (st_q)
      IDLE: begin
        if (start_i) begin
          work_d = state_i;
          rnd_d  = 4'd12 - n_eff;
          st_d   = RUN;
        end
      end
      RUN: begin
        work_d = nxt;
        if (last) begin
          out_d = nxt;
          st_d  = DONE;
        end else begin
          rnd_d = rnd_q + STEP;
        end
      end
      DONE: begin
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      st_q   <= IDLE;
      rnd_q  <= '0;
      work_q <= '0;
      out_q  <= '0;
    end else begin
      st_q   <= st_d;
      rnd_q  <= rnd_d;
      work_q <= work_d;
      out_q  <= out_d;
    end
  end

  assign state_o = out_q;
  assign busy_o  = (st_q == RUN);
  assign done_o  = (st_q == DONE);

endmodule

// File: tb/tb_ascon_permutation.sv
// Self-checking bench for ascon_permutation against a bitsliced reference.
// Honours PERM_UNROLL2_EN for the expected latency.
module tb_ascon_permutation;
  import ascon_pack::*;

  logic       clock_i = 1'b0;
  logic       resetb_i;
  logic       start_i;
  logic [3:0] nrounds_i;
  type_state  state_i;
  type_state  state_o;
  logic       busy_o;
  logic       done_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_i = ~clock_i;

  ascon_permutation #(.MAX_ROUNDS(12)) dut (
    .clock_i   (clock_i),
    .resetb_i  (resetb_i),
    .start_i   (start_i),
    .nrounds_i (nrounds_i),
    .state_i   (state_i),
    .state_o   (state_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  function automatic logic [63:0] ror(input logic [63:0] x, input int k);
    return (x >> k) | (x << (64 - k));
  endfunction

  function automatic int clampn(input int nr);
    if (nr == 0) return 1;
    if (nr > 12) return 12;
    return nr;
  endfunction

  function automatic int exp_lat(input int nr);
`ifdef PERM_UNROLL2_EN
    return (clampn(nr) + 1) / 2;
`else
    return clampn(nr);
`endif
  endfunction

  // Reference: the bitsliced round from the ASCON C implementation.
  function automatic type_state ref_perm(input type_state s, input int nr);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    int n;
    n = clampn(nr);
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    for (int r = 12 - n; r < 12; r++) begin
      x2 ^= 64'(((15 - r) << 4) | r);
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
      t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= ror(x0, 19) ^ ror(x0, 28);
      x1 ^= ror(x1, 61) ^ ror(x1, 39);
      x2 ^= ror(x2, 1) ^ ror(x2, 6);
      x3 ^= ror(x3, 10) ^ ror(x3, 17);
      x4 ^= ror(x4, 7) ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input type_state act, input type_state exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that raised done_o.
  task automatic run(input type_state s, input logic [3:0] nr,
                     output type_state res, output int lat, output int acc);
    start_i = 1'b1;
    state_i = s;
    nrounds_i = nr;
    acc = 0;
    lat = -1;
    res = '0;
    do begin
      @(posedge clock_i); #1;
      acc++;
    end while (!busy_o && acc < 8);
    start_i = 1'b0;
    if (!busy_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept: start not taken within %0d cycles", acc);
      return;
    end
    lat = 0;
    while (!done_o && lat < 40) begin
      @(posedge clock_i); #1;
      lat++;
    end
    res = state_o;
  endtask

  typedef struct {
    string     name;
    logic [3:0] nr;
    type_state s_in;
    type_state s_exp;
    int        lat_exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    type_state res, res2, a, b, hold;
    type_state r0;
    int lat, lat2, acc;
    logic [63:0] c;
    logic seen_done;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    type_state res, res2, a, b, hold, r0;
    int lat, lat2, acc;
    logic [63:0] c;
    logic seen_done;

    vecs[0].name = "p1_zero";   vecs[0].nr = 4'd1;  vecs[0].s_in = '0;
    vecs[1].name = "p12_iv";    vecs[1].nr = 4'd12;
    vecs[1].s_in = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[2].name = "p0_as_p1";  vecs[2].nr = 4'd0;  vecs[2].s_in = rand_state();
    vecs[3].name = "p15_clamp"; vecs[3].nr = 4'd15; vecs[3].s_in = rand_state();
    vecs[4].name = "p3";        vecs[4].nr = 4'd3;  vecs[4].s_in = rand_state();
    vecs[5].name = "p7";        vecs[5].nr = 4'd7;  vecs[5].s_in = rand_state();
    vecs[6].name = "p2";        vecs[6].nr = 4'd2;  vecs[6].s_in = rand_state();
    foreach (vecs[i]) begin
      vecs[i].s_exp   = ref_perm(vecs[i].s_in, int'(vecs[i].nr));
      vecs[i].lat_exp = exp_lat(int'(vecs[i].nr));
    end

    resetb_i = 1'b1;
    start_i = 1'b0;
    nrounds_i = 4'd0;
    state_i = '0;
    #3 resetb_i = 1'b0;
    #1;
    chk_state("reset_state_o", state_o, '0);
    chk_int("reset_busy", busy_o, 0);
    chk_int("reset_done", done_o, 0);
    @(posedge clock_i); #1;
    resetb_i = 1'b1;
    @(posedge clock_i); #1;

    foreach (vecs[i]) begin
      run(vecs[i].s_in, vecs[i].nr, res, lat, acc);
      chk_state({vecs[i].name, "_state"}, res, vecs[i].s_exp);
      chk_int({vecs[i].name, "_lat"}, lat, vecs[i].lat_exp);
      if (i == 0) r0 = res;
    end

    // Hand-derived single round on the zero state.
    c = 64'h4b;
    chk_w("p1_zero_x0", r0[0], c ^ ror(c, 19) ^ ror(c, 28));
    chk_w("p1_zero_x2", r0[2], ~(c ^ ror(c, 1) ^ ror(c, 6)));
    chk_w("p1_zero_x4", r0[4], 64'h0);

    // Result holds while idle.
    hold = state_o;
    repeat (4) begin @(posedge clock_i); #1; end
    chk_state("hold_after_done", state_o, hold);

    // p6 then p8 back-to-back, start raised right as done_o shows.
    a = rand_state();
    b = rand_state();
    run(a, 4'd6, res, lat, acc);
    run(b, 4'd8, res2, lat2, acc);
    chk_state("b2b_p6_state", res, ref_perm(a, 6));
    chk_int("b2b_p6_lat", lat, exp_lat(6));
    chk_state("b2b_p8_state", res2, ref_perm(b, 8));
    chk_int("b2b_p8_lat", lat2, exp_lat(8));
    chk_int("b2b_accept_cycles", acc, 2);

    // Start pulse with another state in the middle of a run.
    repeat (2) begin @(posedge clock_i); #1; end
    a = rand_state();
    b = rand_state();
    start_i = 1'b1; state_i = a; nrounds_i = 4'd12;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 40) begin
      if (lat == 2) begin start_i = 1'b1; state_i = b; nrounds_i = 4'd1; end
      if (lat == 3) start_i = 1'b0;
      @(posedge clock_i); #1;
      lat++;
    end
    start_i = 1'b0;
    chk_state("busy_start_state", state_o, ref_perm(a, 12));
    chk_int("busy_start_lat", lat, exp_lat(12));
    @(posedge clock_i); #1;
    @(posedge clock_i); #1;
    chk_int("busy_start_idle", busy_o, 0);

    // Reset in the middle of a p12.
    a = rand_state();
    start_i = 1'b1; state_i = a; nrounds_i = 4'd12;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clock_i); #1; end
    resetb_i = 1'b0;
    #1;
    chk_state("midreset_state_o", state_o, '0);
    chk_int("midreset_busy", busy_o, 0);
    chk_int("midreset_done", done_o, 0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clock_i); #1;
      if (done_o) seen_done = 1'b1;
    end
    resetb_i = 1'b1;
    repeat (15) begin
      @(posedge clock_i); #1;
      if (done_o) seen_done = 1'b1;
    end
    chk_int("midreset_no_done", seen_done, 0);

    b = rand_state();
    run(b, 4'd12, res, lat, acc);
    chk_state("post_reset_p12_state", res, ref_perm(b, 12));
    chk_int("post_reset_p12_lat", lat, exp_lat(12));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_permutation.md
Name: ascon_permutation

Overview:
- Iterative ASCON permutation engine that applies 1-12 rounds to the 320-bit state, one round per clock.
- Each round runs three layers in order:
  - pC: round-constant addition into x2.
  - pS: substitution layer, 64 instances of the existing 5-bit sbox, one per bit column.
  - pL: linear diffusion, applied to the sbox outputs.
- Sits between the mode-level FSM (init/AD/encrypt/finalize) and the state register; it consumes the sbox outputs directly.

Parameters:
- MAX_ROUNDS, 12, upper bound on the rounds per call; nrounds_i values above it are clamped to it.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous reset, active low.
- start_i  in  1  request a permutation run; sampled only in IDLE.
- nrounds_i  in  4  rounds to apply (1..12); sampled with start_i.
- state_i  in  320 (type_state)  input state x0..x4; sampled with start_i.
- state_o  out  320 (type_state)  permuted state, registered.
- busy_o  out  1  high while rounds are in progress.
- done_o  out  1  one-cycle pulse when state_o is valid.

Behaviour:
- Reset: async on resetb_i low. FSM=IDLE, state_o=0, round counter=0, busy_o=0, done_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start_i=1, latch state_i into the working register and set round index r = 12 - n.
  - n is nrounds_i, with 0 treated as 1 and values above MAX_ROUNDS clamped.
  - Go to RUN. busy_o=1 from the next cycle.
- RUN: each cycle computes working <= pL(pS(pC(working, r))) and increments r.
  - When r reaches 11, that round is the last; go to DONE.
  - start_i is ignored in RUN.
- DONE: state_o holds the result, done_o=1 for exactly one cycle, busy_o=0. Return to IDLE.
  - state_o holds its value until the next DONE.
- Latency: start accepted at cycle T, done_o at cycle T+n+1. The earliest next start is the cycle after done_o.
- pC: x2[7:0] ^= {~r[3:0], r[3:0]}. This gives 0xf0 for r=0 and 0x4b for r=11.
- pS, column j (0..63):
  - sbox input = {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as the MSB.
  - The output bits are written back in the same order.
- pL (ror = rotate right on 64 bits):
  - x0 ^= ror(x0,19) ^ ror(x0,28)
  - x1 ^= ror(x1,61) ^ ror(x1,39)
  - x2 ^= ror(x2,1) ^ ror(x2,6)
  - x3 ^= ror(x3,10) ^ ror(x3,17)
  - x4 ^= ror(x4,7) ^ ror(x4,41)
- Reset mid-run: the run is aborted immediately, with all outputs at their reset values and no done_o pulse.
- start_i held high across the DONE→IDLE transition: treated as a new request in IDLE (back-to-back runs are legal).

Optional Feature:
- Macro: PERM_UNROLL2_EN.
- Defined:
  - Two rounds are chained combinationally per cycle (128 sbox instances) and r advances by 2.
  - Odd n: the final RUN cycle applies one round only.
  - Latency is T+ceil(n/2)+1.
- Undefined: one round per cycle, as above.
- Results are bit-identical in both builds.

Decomposition:
- ascon_pack (shared package):
  - type_state (array [0:4] of logic[63:0]).
  - FSM enum type.
  - ROUND_CONST function/array.
  - Rotation amounts as localparams.
- The sbox is reused unchanged, 64 instances in a generate loop.
- One natural combinational sub-module: diffusion_layer (pL only), instantiated once per unrolled round.
- Everything else lives in ascon_permutation.

Test Plan:
- Reset:
  - Stimulus: resetb_i low at any cycle.
  - Response: state_o=0, busy_o=0, done_o=0 asynchronously, before the next clock edge.
- Single round, zero state:
  - Stimulus: start_i with nrounds_i=1 and all-zero state.
  - Response: done_o 2 cycles after start.
  - x4_o=0.
  - x2_o = ~(0x4b ^ ror(0x4b,1) ^ ror(0x4b,6)).
  - x0_o = 0x4b ^ ror(0x4b,19) ^ ror(0x4b,28).
- p12 against golden model:
  - Stimulus: state {0x80400c0600000000, key=0, nonce=0} with nrounds_i=12.
  - Response: state_o matches the C reference model; done_o at T+13.
- p6 and p8:
  - Stimulus: random state with nrounds_i=6, then nrounds_i=8, back-to-back.
  - Response: each result matches the model; done_o at T+7 and T+9; no lost start.
- Start while busy:
  - Stimulus: pulse start_i with a different state mid-RUN.
  - Response: the pulse is ignored; the result equals the first request's result.
- Reset mid-run:
  - Stimulus: resetb_i low at round 5 of 12.
  - Response: outputs are zero and no done_o pulse.
  - After release, a new p12 completes correctly; with PERM_UNROLL2_EN, the same p12 gives done_o at T+7.
